// File: rtl/mult_pipeline_pkg.sv
// Shared constants for the five-stage multiply pipeline.
// MULT_OVF_EN widens the accumulators to 2*DATA_W so the overflow check can see the full product.
package mult_pipeline_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int MULT_STAGES = 5;
  localparam int MULT_SLICES = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic int acc_width(input int data_w);
`ifdef MULT_OVF_EN
    return 2 * data_w;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/mult_pipeline_if.sv
// Issue/writeback/hazard bundle between the issue stage, the mult pipeline and its consumers.
// out_ovf exists only when MULT_OVF_EN is defined.
interface mult_pipeline_if
  import mult_pipeline_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_src1_val;
  logic [DATA_W-1:0] in_src2_val;
  reg_addr_t         in_dst_reg;
  logic              in_regwrite;
  logic              hold;
  logic              flush;
  logic              in_ready;

  reg_addr_t         m1_dst_reg;
  reg_addr_t         m2_dst_reg;
  reg_addr_t         m3_dst_reg;
  reg_addr_t         m4_dst_reg;
  reg_addr_t         m5_dst_reg;
  logic              m1_regwrite;
  logic              m2_regwrite;
  logic              m3_regwrite;
  logic              m4_regwrite;
  logic              m5_regwrite;

  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  reg_addr_t         out_dst_reg;
  logic              out_regwrite;
`ifdef MULT_OVF_EN
  logic              out_ovf;
`endif

  modport master (
    output in_valid, in_src1_val, in_src2_val, in_dst_reg, in_regwrite, hold, flush,
    input  in_ready,
    input  m1_dst_reg, m2_dst_reg, m3_dst_reg, m4_dst_reg, m5_dst_reg,
    input  m1_regwrite, m2_regwrite, m3_regwrite, m4_regwrite, m5_regwrite,
`ifdef MULT_OVF_EN
    input  out_ovf,
`endif
    input  out_valid, out_result, out_dst_reg, out_regwrite
  );

  modport slave (
    input  in_valid, in_src1_val, in_src2_val, in_dst_reg, in_regwrite, hold, flush,
    output in_ready,
    output m1_dst_reg, m2_dst_reg, m3_dst_reg, m4_dst_reg, m5_dst_reg,
    output m1_regwrite, m2_regwrite, m3_regwrite, m4_regwrite, m5_regwrite,
`ifdef MULT_OVF_EN
    output out_ovf,
`endif
    output out_valid, out_result, out_dst_reg, out_regwrite
  );

endinterface

// File: rtl/mult_stage_reg.sv
// One pipeline stage register: flush kills valid/regwrite, hold freezes everything.
module mult_stage_reg
  import mult_pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              valid_next,
  input  logic              regwrite_next,
  input  reg_addr_t         dst_next,
  input  logic [ACC_W-1:0]  acc_next,
  input  logic [DATA_W-1:0] a_next,
  input  logic [DATA_W-1:0] b_next,
  output logic              valid,
  output logic              regwrite,
  output reg_addr_t         dst_reg,
  output logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      regwrite <= 1'b0;
      dst_reg  <= '0;
      acc      <= '0;
      a        <= '0;
      b        <= '0;
    end else if (flush) begin
      valid    <= 1'b0;
      regwrite <= 1'b0;
    end else if (!hold) begin
      valid    <= valid_next;
      regwrite <= regwrite_next;
      dst_reg  <= dst_next;
      acc      <= acc_next;
      a        <= a_next;
      b        <= b_next;
    end
  end

endmodule

// File: rtl/mult_pipeline.sv
// Five-stage signed multiplier: B is split into four slices accumulated over M2..M4.
// MULT_OVF_EN adds a registered out_ovf flag computed on the full 2*DATA_W sum.
module mult_pipeline
  import mult_pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = MULT_STAGES
) (
  input  logic           clk,
  input  logic           rst,
  mult_pipeline_if.slave bus
);

  localparam int SLICE_W = DATA_W / MULT_SLICES;
  localparam int ACC_W   = acc_width(DATA_W);

  logic              stage_valid    [1:STAGES];
  logic              stage_regwrite [1:STAGES];
  reg_addr_t         stage_dst      [1:STAGES];
  logic [ACC_W-1:0]  stage_acc      [1:STAGES];
  logic [DATA_W-1:0] stage_a        [1:STAGES];
  logic [DATA_W-1:0] stage_b        [1:STAGES];

  logic              valid_in    [1:STAGES];
  logic              regwrite_in [1:STAGES];
  reg_addr_t         dst_in      [1:STAGES];
  logic [ACC_W-1:0]  acc_in      [1:STAGES];
  logic [DATA_W-1:0] a_in        [1:STAGES];
  logic [DATA_W-1:0] b_in        [1:STAGES];

  // Sign-extended A times one B slice, shifted into place; only the top slice is signed.
  function automatic logic [ACC_W-1:0] partial(input logic [DATA_W-1:0] op_a,
                                               input logic [SLICE_W-1:0] slice,
                                               input logic slice_signed,
                                               input int idx);
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    a_ext = ACC_W'($signed(op_a));
    b_ext = slice_signed ? ACC_W'($signed(slice)) : ACC_W'(slice);
    return (a_ext * b_ext) << (idx * SLICE_W);
  endfunction

  always_comb begin
    valid_in[1]    = bus.in_valid;
    regwrite_in[1] = bus.in_regwrite;
    dst_in[1]      = bus.in_dst_reg;
    a_in[1]        = bus.in_src1_val;
    b_in[1]        = bus.in_src2_val;
    for (int k = 2; k <= STAGES; k++) begin
      valid_in[k]    = stage_valid[k-1];
      regwrite_in[k] = stage_regwrite[k-1];
      dst_in[k]      = stage_dst[k-1];
      a_in[k]        = stage_a[k-1];
      b_in[k]        = stage_b[k-1];
    end
  end

  always_comb begin
    acc_in[1] = '0;
    acc_in[2] = stage_acc[1]
              + partial(stage_a[1], stage_b[1][0*SLICE_W +: SLICE_W], 1'b0, 0)
              + partial(stage_a[1], stage_b[1][1*SLICE_W +: SLICE_W], 1'b0, 1);
    acc_in[3] = stage_acc[2] + partial(stage_a[2], stage_b[2][2*SLICE_W +: SLICE_W], 1'b0, 2);
    acc_in[4] = stage_acc[3] + partial(stage_a[3], stage_b[3][3*SLICE_W +: SLICE_W], 1'b1, 3);
    acc_in[5] = stage_acc[4];
  end

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      mult_stage_reg #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_stage (
        .clk           (clk),
        .rst           (rst),
        .hold          (bus.hold),
        .flush         (bus.flush),
        .valid_next    (valid_in[gi]),
        .regwrite_next (regwrite_in[gi]),
        .dst_next      (dst_in[gi]),
        .acc_next      (acc_in[gi]),
        .a_next        (a_in[gi]),
        .b_next        (b_in[gi]),
        .valid         (stage_valid[gi]),
        .regwrite      (stage_regwrite[gi]),
        .dst_reg       (stage_dst[gi]),
        .acc           (stage_acc[gi]),
        .a             (stage_a[gi]),
        .b             (stage_b[gi])
      );
    end
  endgenerate

  assign bus.in_ready    = !bus.hold;

  assign bus.m1_dst_reg  = stage_dst[1];
  assign bus.m2_dst_reg  = stage_dst[2];
  assign bus.m3_dst_reg  = stage_dst[3];
  assign bus.m4_dst_reg  = stage_dst[4];
  assign bus.m5_dst_reg  = stage_dst[5];
  assign bus.m1_regwrite = stage_valid[1] & stage_regwrite[1];
  assign bus.m2_regwrite = stage_valid[2] & stage_regwrite[2];
  assign bus.m3_regwrite = stage_valid[3] & stage_regwrite[3];
  assign bus.m4_regwrite = stage_valid[4] & stage_regwrite[4];
  assign bus.m5_regwrite = stage_valid[5] & stage_regwrite[5];

  assign bus.out_valid    = stage_valid[STAGES];
  assign bus.out_result   = stage_acc[STAGES][DATA_W-1:0];
  assign bus.out_dst_reg  = stage_dst[STAGES];
  assign bus.out_regwrite = stage_valid[STAGES] & stage_regwrite[STAGES];

`ifdef MULT_OVF_EN
  logic              ovf_reg;
  logic              ovf_next;
  logic [DATA_W:0]   top_bits;

  // Representable in DATA_W bits iff the upper half plus the result sign bit are all equal.
  assign top_bits = stage_acc[STAGES-1][ACC_W-1:DATA_W-1];
  assign ovf_next = !((&top_bits) || !(|top_bits));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (bus.flush) begin
      ovf_reg <= 1'b0;
    end else if (!bus.hold) begin
      ovf_reg <= ovf_next;
    end
  end

  assign bus.out_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_mult_pipeline.sv
// Self-checking bench for mult_pipeline: directed scenarios then random traffic vs. a slot model.
// Also exercises out_ovf when MULT_OVF_EN is defined.
module tb_mult_pipeline;
  import mult_pipeline_pkg::*;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_pipeline_if #(.DATA_W(DATA_W)) bus ();

  mult_pipeline #(
    .DATA_W (DATA_W),
    .STAGES (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          v;
    bit          rw;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t pipe [1:5];
  int  checks   = 0;
  int  failures = 0;

  function automatic longint full_prod(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 1; k <= 5; k++) pipe[k] = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
  endtask

  // Reference behaviour at one clock edge, applied to the inputs present before that edge.
  task automatic model_edge();
    if (rst) begin
      model_clear();
    end else if (bus.flush) begin
      for (int k = 1; k <= 5; k++) begin
        pipe[k].v  = 1'b0;
        pipe[k].rw = 1'b0;
      end
    end else if (!bus.hold) begin
      for (int k = 5; k >= 2; k--) pipe[k] = pipe[k-1];
      pipe[1] = '{bus.in_valid, bus.in_regwrite, bus.in_dst_reg, bus.in_src1_val, bus.in_src2_val};
    end
  endtask

  task automatic check_all(input string ctx);
    longint p;
    check({ctx, ":in_ready"},     64'(bus.in_ready),     64'(!bus.hold));
    check({ctx, ":m1_dst"},       64'(bus.m1_dst_reg),   64'(pipe[1].dst));
    check({ctx, ":m2_dst"},       64'(bus.m2_dst_reg),   64'(pipe[2].dst));
    check({ctx, ":m3_dst"},       64'(bus.m3_dst_reg),   64'(pipe[3].dst));
    check({ctx, ":m4_dst"},       64'(bus.m4_dst_reg),   64'(pipe[4].dst));
    check({ctx, ":m5_dst"},       64'(bus.m5_dst_reg),   64'(pipe[5].dst));
    check({ctx, ":m1_rw"},        64'(bus.m1_regwrite),  64'(pipe[1].v & pipe[1].rw));
    check({ctx, ":m2_rw"},        64'(bus.m2_regwrite),  64'(pipe[2].v & pipe[2].rw));
    check({ctx, ":m3_rw"},        64'(bus.m3_regwrite),  64'(pipe[3].v & pipe[3].rw));
    check({ctx, ":m4_rw"},        64'(bus.m4_regwrite),  64'(pipe[4].v & pipe[4].rw));
    check({ctx, ":m5_rw"},        64'(bus.m5_regwrite),  64'(pipe[5].v & pipe[5].rw));
    check({ctx, ":out_valid"},    64'(bus.out_valid),    64'(pipe[5].v));
    check({ctx, ":out_regwrite"}, 64'(bus.out_regwrite), 64'(pipe[5].v & pipe[5].rw));
    check({ctx, ":out_dst"},      64'(bus.out_dst_reg),  64'(pipe[5].dst));
    if (pipe[5].v) begin
      p = full_prod(pipe[5].a, pipe[5].b);
      check({ctx, ":out_result"}, 64'(bus.out_result), 64'(p[31:0]));
`ifdef MULT_OVF_EN
      check({ctx, ":out_ovf"}, 64'(bus.out_ovf), 64'(p != longint'($signed(p[31:0]))));
`endif
    end
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input logic rw);
    bus.in_valid    = v;
    bus.in_src1_val = a;
    bus.in_src2_val = b;
    bus.in_dst_reg  = dst;
    bus.in_regwrite = rw;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    model_clear();

    // Reset state
    step("reset");
    step("reset");
    rst = 1'b0;
    step("idle");

    // Back-to-back issue, then dst 0 and regwrite=0 ops
    drive(1'b1, 32'd3, 32'd7, 5'd5, 1'b1);           step("b2b");
    drive(1'b1, -32'sd4, 32'd5, 5'd6, 1'b1);         step("b2b");
    drive(1'b1, 32'h7FFF_FFFF, 32'd2, 5'd7, 1'b1);   step("b2b");
    drive(1'b1, 32'd11, 32'd13, 5'd0, 1'b1);         step("dst0");
    drive(1'b1, 32'd9, 32'hFFFF_FFF7, 5'd9, 1'b0);   step("norw");
`ifdef MULT_OVF_EN
    drive(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd3, 1'b1); step("ovf");
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1); step("ovf");
`endif
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (6) step("drain");

    // Hold for three cycles with the op in M3; in_valid is ignored meanwhile
    drive(1'b1, 32'd123456, -32'sd789, 5'd9, 1'b1);  step("hold_pre");
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    step("hold_pre");
    step("hold_pre");
    bus.hold = 1'b1;
    drive(1'b1, 32'd55, 32'd66, 5'd12, 1'b1);
    repeat (3) step("hold");
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.hold = 1'b0;
    repeat (6) step("hold_post");

    // Flush with ops in M5, M3, M1 and a new op offered the same cycle
    drive(1'b1, 32'd100, 32'd3, 5'd1, 1'b1);         step("flush_pre");
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);           step("flush_pre");
    drive(1'b1, 32'd200, 32'd3, 5'd2, 1'b1);         step("flush_pre");
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);           step("flush_pre");
    drive(1'b1, 32'd300, 32'd3, 5'd3, 1'b1);         step("flush_pre");
    bus.flush = 1'b1;
    drive(1'b1, 32'd400, 32'd3, 5'd4, 1'b1);         step("flush");
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (6) step("flush_post");

    // Random traffic with occasional hold and flush
    repeat (300) begin
      drive($urandom_range(0, 3) != 0, rand_operand(), rand_operand(),
            5'($urandom), 1'($urandom));
      bus.hold  = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      step("rand");
    end
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (6) step("rand_drain");

    // Asynchronous reset in the middle of a full pipeline
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i + 2), 32'd1000, 5'(i + 20), 1'b1);
      step("rst_fill");
    end
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all("rst_async");
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    step("rst_held");
    step("rst_held");
    rst = 1'b0;
    repeat (7) step("rst_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
